// File: rtl/mdu_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit:
// funct3 opcodes, FSM state encoding, iteration counter width and
// the fixed results used by the divide special cases.
package mdu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 5;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(31);

  localparam logic [DATA_W-1:0] ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [DATA_W-1:0] INT_MIN  = 32'h8000_0000;

endpackage

// File: rtl/mdu_restoring_div.sv
// Restoring divider datapath, one quotient bit per step.
// Ports:
//   clk, rst            clock, async active-high reset
//   load                capture dividend/divisor magnitudes, clear remainder
//   step                perform one shift/compare/subtract iteration
//   dividend, divisor   unsigned magnitudes
//   quo_next_c          quotient after the current step (combinational)
//   rem_next_c          remainder after the current step (combinational)
// The parent captures the *_next_c values on the final step edge so the
// result is ready the cycle the FSM enters DONE.
module mdu_restoring_div #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quo_next_c,
  output logic [W-1:0] rem_next_c
);

  logic [W-1:0] quo;
  logic [W-1:0] rem;
  logic [W-1:0] dvs;
  logic [W:0]   shifted;
  logic [W:0]   diff;
  logic         fits;

  // Bring the next dividend bit into the partial remainder and try to subtract.
  always_comb begin
    shifted    = {rem, quo[W-1]};
    diff       = shifted - {1'b0, dvs};
    fits       = (shifted >= {1'b0, dvs});
    rem_next_c = fits ? diff[W-1:0] : shifted[W-1:0];
    quo_next_c = {quo[W-2:0], fits};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo <= '0;
      rem <= '0;
      dvs <= '0;
    end else if (load) begin
      quo <= dividend;
      rem <= '0;
      dvs <= divisor;
    end else if (step) begin
      quo <= quo_next_c;
      rem <= rem_next_c;
    end
  end

endmodule

// File: rtl/mdu_iterative.sv
// Multi-cycle RV32M multiply/divide unit feeding the register-file write port.
// Ports:
//   clk, rst                 clock, async active-high reset
//   start                    request, accepted only when idle
//   funct3                   MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
//   rs1_data, rs2_data       operands
//   rd_addr                  destination register
//   busy                     high while an operation is in flight
//   done                     one-cycle result-valid pulse
//   result                   result, held until the next completion
//   wt_addr                  destination address for the regfile
//   reg_write                regfile write enable (done with nonzero wt_addr)
// Normal ops take 32 iterations; divide-by-zero and signed overflow finish
// straight from IDLE.
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN = DATA_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      wt_addr,
  output logic            reg_write
);

  localparam int unsigned PW = 2 * XLEN;

  state_t           state, state_next;
  logic [CNT_W-1:0] count;
  logic [2:0]       op_q;
  logic             neg_q;
  logic [4:0]       rd_q;
  logic [XLEN-1:0]  mcand;
  logic [PW-1:0]    prod;

  logic             signed_a, signed_b, a_neg, b_neg, res_neg;
  logic [XLEN-1:0]  a_mag, b_mag;
  logic             fast;
  logic [XLEN-1:0]  fast_res;
  logic [XLEN:0]    mul_sum;
  logic [PW-1:0]    prod_next, prod_fix;
  logic [XLEN-1:0]  quo_next_c, rem_next_c;
  logic [XLEN-1:0]  calc_res;
  logic             load, step, enter_done;
  logic [XLEN-1:0]  result_next;
  logic [4:0]       wt_next;

  // Operand signedness, magnitudes and the sign the final result needs.
  always_comb begin
    signed_a = funct3 inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    signed_b = funct3 inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
    a_neg    = signed_a & rs1_data[XLEN-1];
    b_neg    = signed_b & rs2_data[XLEN-1];
    a_mag    = a_neg ? XLEN'(-rs1_data) : rs1_data;
    b_mag    = b_neg ? XLEN'(-rs2_data) : rs2_data;
    // Remainder follows the dividend; quotient and product follow sign mismatch.
    res_neg  = (funct3 == F3_REM) ? a_neg : (a_neg ^ b_neg);
  end

  // Divide-by-zero and INT_MIN / -1 resolve without iterating.
  always_comb begin
    fast     = funct3[2] && ((rs2_data == '0) ||
               (!funct3[0] && rs1_data == INT_MIN && rs2_data == ALL_ONES));
    if (rs2_data == '0) fast_res = funct3[1] ? rs1_data : ALL_ONES;
    else                fast_res = funct3[1] ? '0 : INT_MIN;
  end

  // Shift-add step: add multiplicand to the high half, shift the pair right.
  always_comb begin
    mul_sum   = {1'b0, prod[PW-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_next = {mul_sum, prod[XLEN-1:1]};
    prod_fix  = neg_q ? PW'(-prod_next) : prod_next;
  end

  // Result of the final iteration, sign-corrected and selected by opcode.
  always_comb begin
    case (op_q)
      F3_MUL:                      calc_res = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: calc_res = prod_fix[PW-1:XLEN];
      F3_DIV, F3_DIVU:             calc_res = neg_q ? XLEN'(-quo_next_c) : quo_next_c;
      default:                     calc_res = neg_q ? XLEN'(-rem_next_c) : rem_next_c;
    endcase
  end

  mdu_restoring_div #(.W(XLEN)) u_div (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .step       (step),
    .dividend   (a_mag),
    .divisor    (b_mag),
    .quo_next_c (quo_next_c),
    .rem_next_c (rem_next_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next state plus the values captured when entering DONE.
  always_comb begin
    state_next  = state;
    load        = 1'b0;
    step        = 1'b0;
    enter_done  = 1'b0;
    result_next = result;
    wt_next     = wt_addr;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load = 1'b1;
          if (fast) begin
            state_next  = ST_DONE;
            enter_done  = 1'b1;
            result_next = fast_res;
            wt_next     = rd_addr;
          end else begin
            state_next = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        step = 1'b1;
        if (count == CNT_LAST) begin
          state_next  = ST_DONE;
          enter_done  = 1'b1;
          result_next = calc_res;
          wt_next     = rd_q;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      rd_q      <= '0;
      mcand     <= '0;
      prod      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      reg_write <= 1'b0;
      result    <= '0;
      wt_addr   <= '0;
    end else begin
      busy      <= (state_next != ST_IDLE);
      done      <= enter_done;
      reg_write <= enter_done && (wt_next != 5'd0);
      if (load) begin
        count <= '0;
        op_q  <= funct3;
        neg_q <= res_neg;
        rd_q  <= rd_addr;
        mcand <= a_mag;
        prod  <= {{XLEN{1'b0}}, b_mag};
      end else if (step) begin
        count <= CNT_W'(count + 1'b1);
        prod  <= prod_next;
      end
      if (enter_done) begin
        result  <= result_next;
        wt_addr <= wt_next;
      end
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Scoreboard bench for mdu_iterative: the driver pushes the expected
// completion (value, address, write enable, cycle) for each accepted request;
// a monitor pops and compares whenever done is seen.
module tb_mdu_iterative;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd_addr;
  logic        busy, done, reg_write;
  logic [31:0] result;
  logic [4:0]  wt_addr;

  mdu_iterative dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .funct3    (funct3),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .rd_addr   (rd_addr),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .wt_addr   (wt_addr),
    .reg_write (reg_write)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  wa;
    logic        rw;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int total = 0;
  int bad   = 0;

  // Reference: plain 64-bit arithmetic following the RV32M definitions.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b);
    if (f3 < 3'd4) return 1'b0;
    if (b == 32'd0) return 1'b1;
    return (f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("result", result, e.res);
          chk("wt_addr", 32'(wt_addr), 32'(e.wa));
          chk("reg_write", 32'(reg_write), 32'(e.rw));
          chk("done_cycle", cyc, e.cyc);
        end
      end else begin
        chk("reg_write_idle", 32'(reg_write), 32'd0);
      end
    end
  endtask

  // Present one request for one edge and record what must come back.
  task automatic drive_start(input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] rd);
    exp_t e;
    @(negedge clk);
    funct3 = f3; rs1_data = a; rs2_data = b; rd_addr = rd; start = 1'b1;
    e.res = ref_model(f3, a, b);
    e.wa  = rd;
    e.rw  = (rd != 5'd0);
    e.cyc = cyc + 1 + (is_fast(f3, a, b) ? 0 : 32);
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
    drive_start(f3, a, b, rd);
    wait_done();
  endtask

  initial begin
    logic [2:0]  rf3;
    logic [31:0] ra, rb;
    int          sel;
    rst = 1'b1; start = 1'b0; funct3 = '0; rs1_data = '0; rs2_data = '0; rd_addr = '0;
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_regwr", 32'(reg_write), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_wt_addr", 32'(wt_addr), 32'd0);
    rst = 1'b0;

    // Normal-latency MUL with busy profile.
    drive_start(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
    chk("busy_after_e0", 32'(busy), 32'd1);
    wait_done();
    chk("busy_in_done", 32'(busy), 32'd1);
    @(negedge clk);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("done_pulse_end", 32'(done), 32'd0);

    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6);
    run_op(3'd5, 32'd100, 32'd7, 5'd7);
    run_op(3'd7, 32'd100, 32'd7, 5'd8);
    run_op(3'd5, 32'd5, 32'd0, 5'd9);
    run_op(3'd6, 32'd5, 32'd0, 5'd10);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);

    // Second request at E10 must be ignored.
    drive_start(3'd0, 32'd1234, 32'd5678, 5'd0);
    repeat (9) @(negedge clk);
    funct3 = 3'd5; rs1_data = 32'd99; rs2_data = 32'd3; rd_addr = 5'd17; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Reset at E15 aborts the op silently.
    drive_start(3'd5, 32'd100, 32'd7, 5'd13);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    #1;
    sb_q.delete();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_regwr", 32'(reg_write), 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_wt_addr", 32'(wt_addr), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    run_op(3'd5, 32'd9, 32'd3, 5'd14);

    // Randomized ops, biased toward the divide corner cases.
    for (int i = 0; i < 40; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 7);
      ra  = $urandom;
      rb  = $urandom;
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 2) rb = 32'($urandom_range(1, 15));
      run_op(rf3, ra, rb, 5'($urandom_range(0, 31)));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
